// File: rtl/whack_pkg.sv
// Shared encodings and helpers for the whack-a-mole game controller.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package whack_pkg;

  // Game phase encodings, also driven out as game_state
  localparam logic [1:0] PH_IDLE    = 2'd0;
  localparam logic [1:0] PH_PLAYING = 2'd1;
  localparam logic [1:0] PH_PAUSED  = 2'd2;
  localparam logic [1:0] PH_OVER    = 2'd3;

  // Mole sub-FSM encodings
  localparam logic [0:0] MS_WAIT = 1'b0;
  localparam logic [0:0] MS_UP   = 1'b1;

  // 8-bit Fibonacci LFSR taps 8,6,5,4 (bit 7 is tap 8)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [3:0] SCORE_MAX = 4'd15;

  function automatic logic [3:0] score_sat_inc(input logic [3:0] s);
    return (s == SCORE_MAX) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/whack_game_ctrl_if.sv
// Button, timer and display signals between the game controller and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a level or a single-cycle pulse.
interface whack_game_ctrl_if #(
  parameter int NUM_HOLES = 4
);
  logic                 start_btn;
  logic                 pause_btn;
  logic [NUM_HOLES-1:0] hit_btn;
  logic                 timer_done;
  logic                 timer_rst;
  logic                 timer_enable;
  logic                 timer_pause;
  logic                 tick;
  logic [NUM_HOLES-1:0] mole_onehot;
  logic [3:0]           score;
  logic                 game_over;
  logic [1:0]           game_state;

  // Player / game_timer side
  modport master (
    output start_btn, pause_btn, hit_btn, timer_done,
    input  timer_rst, timer_enable, timer_pause, tick, mole_onehot,
           score, game_over, game_state
  );

  // Controller side
  modport slave (
    input  start_btn, pause_btn, hit_btn, timer_done,
    output timer_rst, timer_enable, timer_pause, tick, mole_onehot,
           score, game_over, game_state
  );
endinterface

// File: rtl/whack_game_ctrl_tick_prescaler.sv
// Divides clk down to a one-cycle game tick every TICKS_PER_SEC enabled cycles.
// Latency: tick is combinational from the count; first tick in the TICKS_PER_SEC-th enabled cycle after clear.
// Backpressure: none; count freezes while i_count_en is low.
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_count_en,
  input  logic i_clear,
  output logic o_tick
);
  localparam int            CW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] r_count;

  // Tick only while counting, so a count frozen at LAST cannot fire during pause
  assign o_tick = i_count_en && (r_count == LAST);

  // Count 0..LAST while enabled, wrap on the tick cycle; clear wins
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en) begin
      r_count <= o_tick ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole sequencer: game phases, timer drive, game tick, mole scheduling and scoring.
// Latency: button to phase change 1 cycle; hit to score 1 cycle; timer levels combinational from phase.
// Backpressure: none; unaccepted button pulses are simply dropped.
module whack_game_ctrl #(
  parameter int         TICKS_PER_SEC  = 100_000_000,
  parameter int         NUM_HOLES      = 4,
  parameter int         MOLE_UP_TICKS  = 2,
  parameter int         MOLE_GAP_TICKS = 1,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  whack_game_ctrl_if.slave io
);
  import whack_pkg::*;

  localparam int HW = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;

  logic [1:0]           r_phase;
  logic [0:0]           r_msub;
  logic [7:0]           r_mole_cnt;
  logic [NUM_HOLES-1:0] r_mole;
  logic [HW-1:0]        r_prev_hole;
  logic [3:0]           r_score;
  logic                 r_timer_rst;
  logic [7:0]           r_lfsr;

  logic                 w_playing;
  logic                 w_paused;
  logic                 w_start;
  logic                 w_to_over;
  logic                 w_hit;
  logic                 w_tick;
  logic [7:0]           w_cnt_next;
  logic [HW-1:0]        w_hole_raw;
  logic [HW-1:0]        w_hole;
  logic [NUM_HOLES-1:0] w_hole_onehot;

  assign w_playing  = (r_phase == PH_PLAYING);
  assign w_paused   = (r_phase == PH_PAUSED);
  // start only counts from IDLE/OVER, and there it beats a simultaneous pause
  assign w_start    = ((r_phase == PH_IDLE) || (r_phase == PH_OVER)) && io.start_btn;
  assign w_to_over  = (w_playing || w_paused) && io.timer_done;
  // exact pattern match: wrong hole or extra bits never score
  assign w_hit      = w_playing && (r_msub == MS_UP) && (io.hit_btn == r_mole);
  assign w_cnt_next = r_mole_cnt + 8'd1;

  // Never repeat the previous hole: bump by one, wrapping naturally (NUM_HOLES is 2^HW)
  assign w_hole_raw    = r_lfsr[HW-1:0];
  assign w_hole        = (w_hole_raw == r_prev_hole) ? w_hole_raw + HW'(1) : w_hole_raw;
  assign w_hole_onehot = NUM_HOLES'(1) << w_hole;

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_count_en(w_playing),
    .i_clear   (w_start),
    .o_tick    (w_tick)
  );

  // Phase FSM; timer_done outranks pause in both live phases
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= PH_IDLE;
    end else begin
      case (r_phase)
        PH_IDLE, PH_OVER: if (w_start) r_phase <= PH_PLAYING;
        PH_PLAYING: begin
          if (io.timer_done)     r_phase <= PH_OVER;
          else if (io.pause_btn) r_phase <= PH_PAUSED;
        end
        default: begin
          if (io.timer_done)     r_phase <= PH_OVER;
          else if (io.pause_btn) r_phase <= PH_PLAYING;
        end
      endcase
    end
  end

  // Timer reload pulse covers exactly the first PLAYING cycle after a start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_timer_rst <= 1'b0;
    else          r_timer_rst <= w_start;
  end

  // Score clears on (re)start and saturates on hits; a hit coincident with timer_done still counts
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_score <= '0;
    else if (w_start) r_score <= '0;
    else if (w_hit)   r_score <= score_sat_inc(r_score);
  end

  // Mole scheduler: WAIT counts gap ticks, UP counts visible ticks; a hit ends UP early
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_msub      <= MS_WAIT;
      r_mole_cnt  <= '0;
      r_mole      <= '0;
      r_prev_hole <= '0;
    end else if (w_start || w_to_over || w_hit) begin
      r_msub     <= MS_WAIT;
      r_mole_cnt <= '0;
      r_mole     <= '0;
    end else if (w_tick) begin
      if (r_msub == MS_WAIT) begin
        if (w_cnt_next >= 8'(MOLE_GAP_TICKS)) begin
          r_msub      <= MS_UP;
          r_mole_cnt  <= '0;
          r_mole      <= w_hole_onehot;
          r_prev_hole <= w_hole;
        end else begin
          r_mole_cnt <= w_cnt_next;
        end
      end else begin
        if (w_cnt_next >= 8'(MOLE_UP_TICKS)) begin
          r_msub     <= MS_WAIT;
          r_mole_cnt <= '0;
          r_mole     <= '0;
        end else begin
          r_mole_cnt <= w_cnt_next;
        end
      end
    end
  end

  // Free-running LFSR so hole choice depends on when the player started
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_lfsr <= LFSR_SEED;
    else          r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign io.timer_rst    = r_timer_rst;
  assign io.timer_enable = w_playing || w_paused;
  assign io.timer_pause  = w_paused;
  assign io.tick         = w_tick;
  assign io.mole_onehot  = r_mole;
  assign io.score        = r_score;
  assign io.game_over    = (r_phase == PH_OVER);
  assign io.game_state   = r_phase;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Self-checking bench for whack_game_ctrl with a small score scoreboard.
// Latency: checks 1-cycle button/hit latency and TICKS_PER_SEC tick spacing.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_whack_game_ctrl;
  localparam int TPS = 4;
  localparam int NH  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  whack_game_ctrl_if #(.NUM_HOLES(NH)) bus ();

  whack_game_ctrl #(
    .TICKS_PER_SEC (TPS),
    .NUM_HOLES     (NH),
    .MOLE_UP_TICKS (2),
    .MOLE_GAP_TICKS(1),
    .LFSR_SEED     (8'hA5)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io     (bus)
  );

  int             n_tests = 0;
  int             n_fail  = 0;
  logic [31:0]    exp_q[$];
  int             model_score = 0;
  logic [NH-1:0]  prev_mole = '0;
  int             mole_count = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] got);
    logic [31:0] e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = 32'hFFFF_FFFF;
    chk(tag, got, e);
  endtask

  function automatic logic [NH-1:0] rot(input logic [NH-1:0] m);
    return {m[NH-2:0], m[NH-1]};
  endfunction

  // Record the mole currently shown and check it is one-hot and not a repeat
  task automatic note_mole();
    chk("mole_onehot", 32'($onehot(bus.mole_onehot)), 1);
    if (mole_count > 0) chk("no_repeat", 32'(bus.mole_onehot != prev_mole), 1);
    prev_mole = bus.mole_onehot;
    mole_count++;
  endtask

  // Wait for the current mole (if any) to go down and a new one to come up
  task automatic wait_new_mole();
    int n = 0;
    while (bus.mole_onehot != '0 && n < 40) begin step(); n++; end
    while (bus.mole_onehot == '0 && n < 40) begin step(); n++; end
    chk("mole_seen", 32'(bus.mole_onehot != '0), 1);
    note_mole();
  endtask

  // Drive one hit pattern; the expected score goes on the scoreboard now and is checked next cycle
  task automatic do_hit(input logic [NH-1:0] pattern, input bit scores, input string tag);
    bus.hit_btn = pattern;
    if (scores && model_score < 15) model_score++;
    exp_q.push_back(32'(model_score));
    step();
    bus.hit_btn = '0;
    sb_pop(tag, 32'(bus.score));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad_tick;
    int bad_mole;
    int n;
    logic [NH-1:0] saved;

    bus.start_btn  = 1'b0;
    bus.pause_btn  = 1'b0;
    bus.hit_btn    = '0;
    bus.timer_done = 1'b0;

    // Reset values
    repeat (2) step();
    chk("rst_state",  32'(bus.game_state), 0);
    chk("rst_score",  32'(bus.score), 0);
    chk("rst_mole",   32'(bus.mole_onehot), 0);
    chk("rst_tick",   32'(bus.tick), 0);
    chk("rst_trst",   32'(bus.timer_rst), 0);
    chk("rst_ten",    32'(bus.timer_enable), 0);
    chk("rst_tpause", 32'(bus.timer_pause), 0);
    chk("rst_over",   32'(bus.game_over), 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Start at cycle 5
    bus.start_btn = 1'b1;
    step();
    bus.start_btn = 1'b0;
    chk("start_state",  32'(bus.game_state), 1);
    chk("start_trst",   32'(bus.timer_rst), 1);
    chk("start_ten",    32'(bus.timer_enable), 1);
    chk("start_tpause", 32'(bus.timer_pause), 0);
    for (int p = 1; p <= 4; p++) begin
      chk("first_tick", 32'(bus.tick), 32'(p == 4));
      chk("no_mole_yet", 32'(bus.mole_onehot), 0);
      step();
      if (p == 1) chk("trst_one_cycle", 32'(bus.timer_rst), 0);
    end
    chk("first_mole_up", 32'(bus.mole_onehot != '0), 1);
    note_mole();

    // Correct hit, press with no mole, multi-bit and wrong-hole presses
    do_hit(prev_mole, 1'b1, "hit_score");
    chk("hit_clears_mole", 32'(bus.mole_onehot), 0);
    do_hit(4'b0001, 1'b0, "nomole_press");
    wait_new_mole();
    do_hit(prev_mole | rot(prev_mole), 1'b0, "multi_press");
    chk("multi_mole_kept", 32'(bus.mole_onehot), 32'(prev_mole));
    do_hit(rot(prev_mole), 1'b0, "wrong_hole");
    chk("wrong_mole_kept", 32'(bus.mole_onehot), 32'(prev_mole));

    // Pause on the first UP tick, hold 20 cycles, resume with one UP tick left
    n = 0;
    while (!bus.tick && n < 10) begin step(); n++; end
    chk("up_tick_seen", 32'(bus.tick), 1);
    bus.pause_btn = 1'b1;
    step();
    bus.pause_btn = 1'b0;
    chk("pause_state",  32'(bus.game_state), 2);
    chk("pause_tpause", 32'(bus.timer_pause), 1);
    chk("pause_ten",    32'(bus.timer_enable), 1);
    chk("pause_mole",   32'(bus.mole_onehot), 32'(prev_mole));
    saved = bus.mole_onehot;
    do_hit(saved, 1'b0, "paused_hit");
    bad_tick = 0;
    bad_mole = 0;
    repeat (20) begin
      step();
      if (bus.tick) bad_tick++;
      if (bus.mole_onehot != saved) bad_mole++;
    end
    chk("pause_no_tick", 32'(bad_tick), 0);
    chk("pause_frozen",  32'(bad_mole), 0);
    bus.pause_btn = 1'b1;
    step();
    bus.pause_btn = 1'b0;
    chk("resume_state",  32'(bus.game_state), 1);
    chk("resume_tpause", 32'(bus.timer_pause), 0);
    for (int r = 1; r <= 4; r++) begin
      chk("resume_tick", 32'(bus.tick), 32'(r == 4));
      chk("resume_mole", 32'(bus.mole_onehot), 32'(saved));
      step();
    end
    chk("up_expired", 32'(bus.mole_onehot), 0);

    // Hit together with timer_done: scored, then OVER
    wait_new_mole();
    bus.hit_btn    = prev_mole;
    bus.timer_done = 1'b1;
    if (model_score < 15) model_score++;
    exp_q.push_back(32'(model_score));
    step();
    bus.hit_btn    = '0;
    bus.timer_done = 1'b0;
    sb_pop("end_hit_score", 32'(bus.score));
    chk("end_state", 32'(bus.game_state), 3);
    chk("end_over",  32'(bus.game_over), 1);
    chk("end_mole",  32'(bus.mole_onehot), 0);
    chk("end_ten",   32'(bus.timer_enable), 0);
    step();
    chk("over_score_hold", 32'(bus.score), 32'(model_score));

    // Restart with start and pause together: start wins
    bus.start_btn = 1'b1;
    bus.pause_btn = 1'b1;
    model_score = 0;
    exp_q.push_back(32'(model_score));
    step();
    bus.start_btn = 1'b0;
    bus.pause_btn = 1'b0;
    sb_pop("restart_score", 32'(bus.score));
    chk("restart_state", 32'(bus.game_state), 1);
    chk("restart_trst",  32'(bus.timer_rst), 1);
    chk("restart_over",  32'(bus.game_over), 0);
    step();
    chk("restart_trst_off", 32'(bus.timer_rst), 0);

    // 16 correct hits saturate at 15
    for (int i = 0; i < 16; i++) begin
      wait_new_mole();
      do_hit(prev_mole, 1'b1, "sat_hit");
    end
    chk("sat_final", 32'(bus.score), 15);

    // Let moles come and go untouched until at least 52 have been seen
    while (mole_count < 52) wait_new_mole();

    // Asynchronous reset between edges while a mole is up
    wait_new_mole();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(bus.game_state), 0);
    chk("arst_score", 32'(bus.score), 0);
    chk("arst_mole",  32'(bus.mole_onehot), 0);
    chk("arst_tick",  32'(bus.tick), 0);
    chk("arst_trst",  32'(bus.timer_rst), 0);
    chk("arst_ten",   32'(bus.timer_enable), 0);
    chk("arst_over",  32'(bus.game_over), 0);
    #3;
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_idle", 32'(bus.game_state), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/whack_game_ctrl.md
Name: whack_game_ctrl

Overview:
- Top-level game sequencer for whack-a-mole.
- Runs game phases IDLE/PLAYING/PAUSED/OVER from player buttons, and drives the game_timer control levels (reload, enable, pause) while consuming its timer_done.
- Generates the one-second game tick, schedules pseudo-random mole appearances, and judges hits.
- Keeps the 4-bit score that feeds score_display.

Parameters:
- TICKS_PER_SEC, 100_000_000, clk cycles per game tick; minimum 2.
- NUM_HOLES, 4, number of holes; power of 2, range 2..8.
- MOLE_UP_TICKS, 2, ticks a mole stays visible.
- MOLE_GAP_TICKS, 1, ticks between a mole going down and the next appearing.
- LFSR_SEED, 8'hA5, non-zero LFSR reset value.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start_btn  in  1  single-cycle pulse: start or restart a game.
- pause_btn  in  1  single-cycle pulse: toggle pause.
- hit_btn  in  NUM_HOLES  single-cycle pulses, one bit per hole.
- timer_done  in  1  from game_timer: countdown expired.
- timer_rst  out  1  one-cycle reload pulse to game_timer.
- timer_enable  out  1  enable level to game_timer.
- timer_pause  out  1  pause level to game_timer.
- tick  out  1  one-cycle pulse per game second.
- mole_onehot  out  NUM_HOLES  visible mole; all zero when none.
- score  out  4  hit count, saturating; feeds score_display.
- game_over  out  1  high in OVER.
- game_state  out  2  current phase: IDLE=0, PLAYING=1, PAUSED=2, OVER=3.

Behaviour:
- Reset (rst_n low, asynchronous): all state and outputs return to known values.
  - Phase = IDLE; score = 0; mole_onehot = 0; tick = 0; timer_rst = 0.
  - Prescaler = 0; mole sub-FSM = WAIT with count 0; LFSR = LFSR_SEED.
  - Reset mid-game aborts immediately; no residual mole or score.
- Phase FSM, registered, updated every clk:
  - IDLE: start_btn -> PLAYING. In the same edge: score <= 0, prescaler <= 0, mole sub-FSM <= WAIT with count 0, and timer_rst pulses high for exactly the first PLAYING cycle.
  - PLAYING:
    - timer_done -> OVER (highest priority).
    - else pause_btn -> PAUSED.
    - start_btn is ignored.
  - PAUSED:
    - pause_btn -> PLAYING.
    - timer_done -> OVER.
    - Prescaler, mole counters and mole_onehot are frozen.
    - hit_btn is ignored.
  - OVER:
    - mole_onehot = 0; score holds.
    - start_btn -> PLAYING with the same restart actions as from IDLE.
- Timer drive, combinational from phase:
  - timer_enable = 1 in PLAYING and PAUSED.
  - timer_pause = 1 in PAUSED only.
  - Both are 0 in IDLE and OVER.
- Tick prescaler:
  - Counts 0..TICKS_PER_SEC-1 only in PLAYING.
  - tick = 1 for the single cycle in which the count equals TICKS_PER_SEC-1, then the count wraps to 0.
  - First tick occurs TICKS_PER_SEC cycles after entering PLAYING.
- Mole sub-FSM, advances only on tick in PLAYING:
  - WAIT: count ticks. When MOLE_GAP_TICKS ticks are reached, choose a hole, set mole_onehot, go to UP with count 0.
  - UP: after MOLE_UP_TICKS ticks, clear mole_onehot and go to WAIT.
- Hole choice:
  - LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances every clk regardless of phase.
  - hole = LFSR[log2(NUM_HOLES)-1:0].
  - If hole equals the previous hole, use (hole+1) mod NUM_HOLES, so the same hole never appears twice in a row.
- Hit judging (PLAYING, mole UP):
  - A hit is hit_btn == mole_onehot exactly.
  - On a hit: score <= min(score+1, 15); mole clears next cycle; sub-FSM goes to WAIT with count 0.
  - A wrong hole, multiple bits set, or any press while no mole is up has no effect.
- Simultaneous events:
  - Hit and timer_done in the same cycle: the hit is scored, then the phase goes to OVER.
  - Hit on the same cycle as the UP-expiry tick: the hit is scored.
  - pause_btn and timer_done in the same cycle: OVER.
  - start_btn and pause_btn in IDLE/OVER: start wins and pause is ignored.
- Latency:
  - Button to phase change: 1 cycle.
  - Hit to score update: 1 cycle.

Decomposition:
- Shared package whack_pkg holds:
  - Phase encodings IDLE/PLAYING/PAUSED/OVER.
  - Mole sub-FSM encodings WAIT/UP.
  - LFSR tap constant.
  - SCORE_MAX = 15.
- One sub-module is natural: tick_prescaler, which takes TICKS_PER_SEC, count_en and clear, and outputs tick.
- LFSR and hit logic stay inline.

Test Plan:
- Bench setup for all scenarios: TICKS_PER_SEC=4, NUM_HOLES=4.
- Start: reset, pulse start_btn at cycle 5 -> game_state=1 and timer_rst=1 for exactly one cycle; timer_enable=1, timer_pause=0; first tick 4 cycles after entry; first mole appears on the tick after MOLE_GAP_TICKS=1 tick.
- Hit: with mole_onehot=4'b0100, pulse hit_btn=4'b0100 -> score 0→1 next cycle, mole_onehot=0. Pulse hit_btn=4'b0110 on a later mole -> score unchanged.
- Saturation: 16 correct hits -> score stays 15.
- Pause: pause_btn mid-UP -> game_state=2, timer_pause=1, no tick, mole frozen for 20 cycles; second pause_btn -> resumes with the remaining UP ticks intact.
- Game end with a hit: timer_done and a correct hit in the same cycle -> score incremented, game_state=3, game_over=1, mole_onehot=0. start_btn then -> score=0, timer_rst pulse, PLAYING.
- Async reset mid-UP: drop rst_n between edges -> all outputs at reset values immediately. Across 50 moles, no hole repeats consecutively.
